pe_dot_sequencer: RTL and testbench

PE_DOT_SEQUENCER -- requirements
Module: pe_dot_sequencer

---
 rtl/pe_dot_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pe_dot_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pe_dot_sequencer.sv
// Sequencer for a dot-product processing element: fetches operand pairs from a buffer,
// streams them into the PE, captures the PE result and offers it on a valid/ready handshake.
module pe_dot_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int MAX_LEN = 16,
    localparam int LEN_W  = $clog2(MAX_LEN + 1),
    localparam int ADDR_W = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_abort,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic [DATA_W-1:0] i_b_data,
    output logic [DATA_W-1:0] o_pe_a,
    output logic [DATA_W-1:0] o_pe_b,
    output logic              o_pe_enable,
    output logic              o_pe_clear,
    input  logic [ACC_W-1:0]  i_pe_result,
    input  logic              i_pe_overflow,
    output logic [ACC_W-1:0]  o_result,
    output logic              o_overflow,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [LEN_W-1:0]   len_r, len_s, k_r, k_s, len_clamp_s;
    logic               rd_en_r, rd_en_s, pe_enable_r, pe_enable_s;
    logic               pe_clear_r, pe_clear_s, valid_r, valid_s, busy_r;
    logic               overflow_r, overflow_s;
    logic [ADDR_W-1:0]  rd_addr_r, rd_addr_s;
    logic [ACC_W-1:0]   result_r, result_s;

    assign len_clamp_s = (i_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_len;

    // Next-state logic; control outputs are computed for the upcoming state and registered.
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        k_s         = k_r;
        rd_en_s     = 1'b0;
        rd_addr_s   = '0;
        pe_enable_s = 1'b0;
        pe_clear_s  = 1'b0;
        valid_s     = 1'b0;
        result_s    = result_r;
        overflow_s  = overflow_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s    = ST_CLEAR;
                    len_s      = len_clamp_s;
                    pe_clear_s = 1'b1;
                    rd_en_s    = (len_clamp_s != LEN_W'(0));
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (i_abort) begin
                    state_s    = ST_IDLE;
                    pe_clear_s = 1'b1;
                end else if (len_r != LEN_W'(0)) begin
                    state_s     = ST_STREAM;
                    k_s         = LEN_W'(0);
                    pe_enable_s = 1'b1;
                    rd_en_s     = (len_r > LEN_W'(1));
                    rd_addr_s   = (len_r > LEN_W'(1)) ? ADDR_W'(1) : ADDR_W'(0);
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_STREAM: begin
                if (i_abort) begin
                    state_s    = ST_IDLE;
                    pe_clear_s = 1'b1;
                end else if (k_r == len_r - LEN_W'(1)) begin
                    state_s = ST_DRAIN;
                end else begin
                    k_s         = k_r + LEN_W'(1);
                    pe_enable_s = 1'b1;
                    // Prefetch one element ahead of the element entering the PE.
                    if ((k_r + LEN_W'(2)) < len_r) begin
                        rd_en_s   = 1'b1;
                        rd_addr_s = ADDR_W'(k_r + LEN_W'(2));
                    end else begin
                        rd_en_s = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (i_abort) begin
                    state_s    = ST_IDLE;
                    pe_clear_s = 1'b1;
                end else begin
                    state_s    = ST_DONE;
                    valid_s    = 1'b1;
                    result_s   = i_pe_result;
                    overflow_s = i_pe_overflow;
                end
            end
            ST_DONE: begin
                if (i_abort) begin
                    state_s    = ST_IDLE;
                    pe_clear_s = 1'b1;
                end else if (i_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            len_r       <= '0;
            k_r         <= '0;
            rd_en_r     <= 1'b0;
            rd_addr_r   <= '0;
            pe_enable_r <= 1'b0;
            pe_clear_r  <= 1'b0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            result_r    <= '0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            k_r         <= k_s;
            rd_en_r     <= rd_en_s;
            rd_addr_r   <= rd_addr_s;
            pe_enable_r <= pe_enable_s;
            pe_clear_r  <= pe_clear_s;
            valid_r     <= valid_s;
            busy_r      <= (state_s != ST_IDLE);
            result_r    <= result_s;
            overflow_r  <= overflow_s;
        end
    end

    // Buffer data arrives in the cycle it is consumed, so operands bypass the registers.
    assign o_pe_a      = pe_enable_r ? i_a_data : '0;
    assign o_pe_b      = pe_enable_r ? i_b_data : '0;
    assign o_rd_en     = rd_en_r;
    assign o_rd_addr   = rd_addr_r;
    assign o_pe_enable = pe_enable_r;
    assign o_pe_clear  = pe_clear_r;
    assign o_valid     = valid_r;
    assign o_busy      = busy_r;
    assign o_result    = result_r;
    assign o_overflow  = overflow_r;

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Bench for pe_dot_sequencer: operand buffer and signed MAC PE models, directed and random jobs
// checked against a reference dot product computed from the operand arrays.
module tb_pe_dot_sequencer;

    logic        clk = 1'b0;
    logic        i_reset, i_start, i_abort, i_ready;
    logic [4:0]  i_len;
    logic [7:0]  i_a_data, i_b_data;
    logic [15:0] i_pe_result;
    logic        i_pe_overflow;
    logic        o_rd_en, o_pe_enable, o_pe_clear, o_overflow, o_valid, o_busy;
    logic [3:0]  o_rd_addr;
    logic [7:0]  o_pe_a, o_pe_b;
    logic [15:0] o_result;

    logic [7:0]  a_mem [16];
    logic [7:0]  b_mem [16];
    int          n_assert = 0;
    int          n_fail   = 0;

    pe_dot_sequencer #(.DATA_W(8), .ACC_W(16), .MAX_LEN(16)) dut (
        .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_len(i_len), .i_abort(i_abort),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_a_data(i_a_data), .i_b_data(i_b_data),
        .o_pe_a(o_pe_a), .o_pe_b(o_pe_b), .o_pe_enable(o_pe_enable), .o_pe_clear(o_pe_clear),
        .i_pe_result(i_pe_result), .i_pe_overflow(i_pe_overflow), .o_result(o_result),
        .o_overflow(o_overflow), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Operand buffer: registered read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (o_rd_en) begin
            i_a_data <= a_mem[o_rd_addr];
            i_b_data <= b_mem[o_rd_addr];
        end
    end

    function automatic int pe_next(logic [15:0] acc, logic [7:0] a, logic [7:0] b);
        return int'($signed(acc)) + int'($signed(a)) * int'($signed(b));
    endfunction

    function automatic logic out_of_range(int v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Signed MAC PE with wrapping accumulator and sticky overflow.
    always @(posedge clk) begin
        if (o_pe_clear) begin
            i_pe_result   <= 16'd0;
            i_pe_overflow <= 1'b0;
        end else if (o_pe_enable) begin
            i_pe_result   <= 16'(pe_next(i_pe_result, o_pe_a, o_pe_b));
            i_pe_overflow <= i_pe_overflow | out_of_range(pe_next(i_pe_result, o_pe_a, o_pe_b));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain dot product; overflow if any exact prefix sum leaves the 16-bit signed range.
    task automatic ref_dot(input int len, output logic [15:0] res, output logic ovf);
        longint sum = 0;
        ovf = 1'b0;
        for (int i = 0; i < len; i++) begin
            sum += longint'($signed(a_mem[i])) * longint'($signed(b_mem[i]));
            if (sum > 32767 || sum < -32768) ovf = 1'b1;
        end
        res = 16'(sum);
    endtask

    task automatic run_job(input string tag, input int len_in, input int hold,
                           input bit pulse_start, input bit abort_done);
        int L, first_valid, en_cnt, clr_cnt, rd_err, proto_err, wait_cnt;
        bit done;
        logic [15:0] exp_res, res0;
        logic exp_ovf, ovf0;
        L = (len_in > 16) ? 16 : len_in;
        ref_dot(L, exp_res, exp_ovf);
        first_valid = -1; en_cnt = 0; clr_cnt = 0; rd_err = 0; proto_err = 0; wait_cnt = 0;
        done = 1'b0; res0 = 16'd0; ovf0 = 1'b0;
        @(negedge clk);
        i_start = 1'b1;
        i_len   = 5'(len_in);
        for (int c = 1; c < 200 && !done; c++) begin
            @(negedge clk);
            if (c == 1) i_start = 1'b0;
            if (o_rd_en !== (c <= L) || (o_rd_en && o_rd_addr !== 4'(c - 1))) rd_err++;
            if (o_pe_enable !== (c >= 2 && c <= L + 1)) proto_err++;
            if (o_pe_clear !== (c == 1)) proto_err++;
            if (!o_pe_enable && (o_pe_a !== 8'd0 || o_pe_b !== 8'd0)) proto_err++;
            if (!o_rd_en && o_rd_addr !== 4'd0) proto_err++;
            if (o_busy !== 1'b1) proto_err++;
            en_cnt  += int'(o_pe_enable);
            clr_cnt += int'(o_pe_clear);
            if (o_valid === 1'b1) begin
                if (first_valid < 0) begin
                    first_valid = c; res0 = o_result; ovf0 = o_overflow;
                end else if (o_result !== res0 || o_overflow !== ovf0) begin
                    proto_err++;
                end
                if (wait_cnt >= hold) begin
                    i_start = 1'b0;
                    i_ready = 1'b1;
                    i_abort = abort_done;
                    done    = 1'b1;
                end else begin
                    wait_cnt++;
                    i_start = pulse_start;
                    i_len   = 5'd3;
                end
            end
        end
        @(negedge clk);
        i_ready = 1'b0;
        i_abort = 1'b0;
        chk({tag, " valid_cycle"}, 32'(first_valid), 32'(L + 3));
        chk({tag, " enables"}, 32'(en_cnt), 32'(L));
        chk({tag, " clears"}, 32'(clr_cnt), 32'd1);
        chk({tag, " reads"}, 32'(rd_err), 32'd0);
        chk({tag, " protocol"}, 32'(proto_err), 32'd0);
        chk({tag, " result"}, 32'(res0), 32'(exp_res));
        chk({tag, " overflow"}, 32'(ovf0), 32'(exp_ovf));
        chk({tag, " idle_after"}, {30'd0, o_busy, o_valid}, 32'd0);
        chk({tag, " clear_after"}, 32'(o_pe_clear), 32'(abort_done));
        chk({tag, " held_result"}, {15'd0, o_overflow, o_result}, {15'd0, exp_ovf, exp_res});
    endtask

    initial begin
        logic [15:0] keep;
        i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0; i_len = 5'd0;
        #1;
        chk("reset_outputs", {26'd0, o_rd_en, o_pe_enable, o_pe_clear, o_valid, o_busy, o_overflow}, 32'd0);
        chk("reset_result", 32'(o_result), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;

        for (int i = 0; i < 16; i++) begin a_mem[i] = 8'd0; b_mem[i] = 8'd0; end
        a_mem[0] = 8'd1; a_mem[1] = 8'd2; a_mem[2] = 8'd3;
        b_mem[0] = 8'd4; b_mem[1] = 8'd5; b_mem[2] = 8'd6;
        run_job("len3", 3, 0, 1'b0, 1'b0);
        chk("len3_value", 32'(o_result), 32'd32);

        for (int i = 0; i < 3; i++) begin a_mem[i] = 8'd127; b_mem[i] = 8'd127; end
        run_job("sat", 3, 1, 1'b0, 1'b0);
        chk("sat_value", {15'd0, o_overflow, o_result}, {15'd0, 1'b1, 16'hBD03});

        run_job("len0", 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin a_mem[i] = 8'($urandom); b_mem[i] = 8'($urandom); end
        run_job("len31", 31, 0, 1'b0, 1'b0);
        run_job("hold5", 5, 5, 1'b1, 1'b0);
        run_job("abort_done", 4, 2, 1'b0, 1'b1);

        // Abort in idle does nothing.
        @(negedge clk); i_abort = 1'b1;
        @(negedge clk); i_abort = 1'b0;
        chk("abort_idle", {30'd0, o_busy, o_pe_clear}, 32'd0);

        // Abort in STREAM at k=1 of a length-4 job.
        keep = o_result;
        @(negedge clk); i_start = 1'b1; i_len = 5'd4;
        @(negedge clk); i_start = 1'b0;
        @(negedge clk);
        @(negedge clk); i_abort = 1'b1;
        @(negedge clk); i_abort = 1'b0;
        chk("abort_stream_state", {28'd0, o_pe_clear, o_busy, o_pe_enable, o_valid}, 32'h8);
        chk("abort_stream_keep", 32'(o_result), 32'(keep));
        @(negedge clk);
        chk("abort_stream_after", {30'd0, o_pe_clear, o_valid}, 32'd0);
        run_job("post_abort", 7, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of STREAM.
        @(negedge clk); i_start = 1'b1; i_len = 5'd5;
        @(negedge clk); i_start = 1'b0;
        @(negedge clk);
        @(negedge clk); i_reset = 1'b1;
        #1;
        chk("midjob_reset", {10'd0, o_rd_en, o_pe_enable, o_pe_clear, o_valid, o_busy, o_overflow, o_result}, 32'd0);
        @(negedge clk); i_reset = 1'b0;
        run_job("post_reset", 9, 0, 1'b0, 1'b0);

        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 16; i++) begin a_mem[i] = 8'($urandom); b_mem[i] = 8'($urandom); end
            run_job("random", int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
